brisc_mem_responder: RTL

Main-memory responder for the brisc core: the memory end of the cache-line fill/writeback interface driven by the instruction and data caches. Accepts one 128-bit line request at a time, models a fixed access latency with a counter, commits writes, and returns the line through a valid/ready response handshake. Sits below the cache arbiter and uses the shared `brisc_pkg` widths (`ADDRESS_BITS`, `CACHE_LINE_LEN`).

---
 rtl/brisc_pkg.sv | 22 ++
 rtl/brisc_mem_array.sv | 21 ++
 rtl/brisc_mem_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/brisc_pkg.sv
// Shared brisc widths plus the memory-responder types (FSM states, request record).
package brisc_pkg;
  localparam int ADDRESS_BITS     = 32;
  localparam int BYTE_LEN         = 8;
  localparam int CACHE_LINE_LEN   = 128;
  localparam int LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN);

  localparam logic [ADDRESS_BITS-1:0] PC_BOOT   = 32'h0000_1000;
  localparam logic [ADDRESS_BITS-1:0] PC_EXCEPT = 32'h0000_2000;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_BUSY,
    MEM_RESP
  } mem_state_e;

  typedef struct packed {
    logic                      we;
    logic [ADDRESS_BITS-1:0]   addr;
    logic [CACHE_LINE_LEN-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/brisc_mem_array.sv
// Single-port line storage: synchronous write, asynchronous read. Contents are never reset.
module brisc_mem_array
  import brisc_pkg::*;
#(
  parameter int LINES = 4096,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic                      clk,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic                      we_i,
  input  logic [CACHE_LINE_LEN-1:0] wdata_i,
  output logic [CACHE_LINE_LEN-1:0] rdata_o
);
  logic [CACHE_LINE_LEN-1:0] mem_q [LINES];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/brisc_mem_responder.sv
// Main-memory responder: one line request at a time, fixed latency, valid/ready response.
// Optional out-of-range detection with `define BRISC_MEM_BOUNDS_CHECK_EN.
module brisc_mem_responder
  import brisc_pkg::*;
#(
  parameter int MEM_LATENCY = 5,
  parameter int MEM_LINES   = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDRESS_BITS-1:0]   req_addr,
  input  logic [CACHE_LINE_LEN-1:0] req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [CACHE_LINE_LEN-1:0] resp_data,
  output logic                      resp_err
);
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  mem_req_t                  req_in;
  logic                      req_oob;
  logic                      unused_addr;
  mem_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CACHE_LINE_LEN-1:0] wdata_q, wdata_d;
  logic                      err_q, err_d;
  logic [CACHE_LINE_LEN-1:0] resp_data_q, resp_data_d;
  logic                      resp_err_q, resp_err_d;
  logic                      arr_we;
  logic [CACHE_LINE_LEN-1:0] arr_rdata;

  assign req_in      = '{we: req_we, addr: req_addr, wdata: req_wdata};
  // Offset bits (and, without bounds checking, the upper bits) carry no meaning here.
  assign unused_addr = ^req_in.addr;

`ifdef BRISC_MEM_BOUNDS_CHECK_EN
  assign req_oob = (req_in.addr >> (LINE_OFFSET_BITS + IDX_W)) != '0;
`else
  assign req_oob = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    arr_we      = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (req_valid) begin
          we_d    = req_in.we;
          idx_d   = req_in.addr[LINE_OFFSET_BITS +: IDX_W];
          wdata_d = req_in.wdata;
          err_d   = req_oob;
          cnt_d   = CNT_LOAD;
          state_d = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        if (cnt_q == '0) begin
          // Write lands on this edge, so any later read sees it.
          arr_we      = we_q & ~err_q;
          resp_err_d  = err_q;
          resp_data_d = err_q ? '0 : (we_q ? wdata_q : arr_rdata);
          state_d     = MEM_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MEM_RESP: begin
        if (resp_ready) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MEM_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  brisc_mem_array #(.LINES(MEM_LINES)) u_array (
    .clk    (clk),
    .idx_i  (idx_q),
    .we_i   (arr_we),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );

  assign req_ready  = (state_q == MEM_IDLE) & rst_n;
  assign resp_valid = (state_q == MEM_RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
endmodule
